// File: rtl/cyclic_frame_ctrl.sv
// cyclic_frame_ctrl: frame sequencer for a serial systematic cyclic encoder.
// Each accepted K-bit word produces one frame. The encoder is cleared for one
// cycle, then fed the message MSB-first for K cycles, then fed N-K zeros so
// that it shifts out its parity. The encoder's serial output is realigned
// into a framed codeword stream.
//
// Ports:
//   clk, reset             clock, synchronous active-high reset
//   data_in/data_valid     K-bit message word and its valid
//   data_ready             word accepted this cycle when data_valid is high
//   enc_enable/enc_reset   encoder clock enable / clear
//   enc_in                 serial bit to encoder
//   enc_out                serial codeword bit from encoder (ENC_LAT cycles behind enc_in)
//   code_out/code_valid    registered codeword bit and qualifier
//   code_sof/code_eof      first / last bit of the codeword
//   busy                   frame in progress or output pipeline non-empty
//
// Optional build macro CYC_CTRL_ERR_INJ_EN adds inj_en/inj_pos: sampled at
// word acceptance, they invert the codeword bit at transmit index inj_pos.
module cyclic_frame_ctrl #(
  parameter int unsigned K       = 11,
  parameter int unsigned N       = 15,
  parameter int unsigned ENC_LAT = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [K-1:0] data_in,
  input  logic         data_valid,
  output logic         data_ready,
  output logic         enc_enable,
  output logic         enc_reset,
  output logic         enc_in,
  input  logic         enc_out,
  output logic         code_out,
  output logic         code_valid,
  output logic         code_sof,
  output logic         code_eof,
  output logic         busy
`ifdef CYC_CTRL_ERR_INJ_EN
  ,
  input  logic                 inj_en,
  input  logic [$clog2(N)-1:0] inj_pos
`endif
);

  localparam int unsigned CW     = $clog2(N);
  localparam int unsigned TW     = 4;
  localparam int unsigned T_V    = 3;
  localparam int unsigned T_SOF  = 2;
  localparam int unsigned T_EOF  = 1;
  localparam int unsigned T_FLIP = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CLR    = 2'd1,
    S_DATA   = 2'd2,
    S_PARITY = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [K-1:0]   sr_q, sr_d;
  logic           accept;
  logic           last_par;
  logic [TW-1:0]  tag_now;
  logic [TW-1:0]  tag_al;
  logic           pipe_busy;
  logic           code_bit_q, code_bit_d;
  logic           code_valid_q, code_valid_d;
  logic           code_sof_q, code_sof_d;
  logic           code_eof_q, code_eof_d;

`ifdef CYC_CTRL_ERR_INJ_EN
  logic           inj_en_q, inj_en_d;
  logic [CW-1:0]  inj_pos_q, inj_pos_d;
`endif

  // Next-state, counter, shift register and encoder-side outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sr_d       = sr_q;
    accept     = 1'b0;
    data_ready = 1'b0;
    enc_enable = 1'b0;
    enc_reset  = 1'b0;
    enc_in     = 1'b0;
    last_par   = (state_q == S_PARITY) && (cnt_q == CW'(N - 1));
`ifdef CYC_CTRL_ERR_INJ_EN
    inj_en_d   = inj_en_q;
    inj_pos_d  = inj_pos_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        data_ready = 1'b1;
        if (data_valid) begin
          accept  = 1'b1;
          state_d = S_CLR;
        end
      end
      S_CLR: begin
        enc_reset = 1'b1;
        cnt_d     = '0;
        state_d   = S_DATA;
      end
      S_DATA: begin
        enc_enable = 1'b1;
        enc_in     = sr_q[K-1];
        sr_d       = sr_q << 1;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == CW'(K - 1)) state_d = S_PARITY;
      end
      S_PARITY: begin
        enc_enable = 1'b1;
        cnt_d      = cnt_q + 1'b1;
        // Final parity slot doubles as the acceptance slot for back-to-back frames
        if (last_par) begin
          data_ready = 1'b1;
          if (data_valid) begin
            accept  = 1'b1;
            state_d = S_CLR;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      sr_d = data_in;
`ifdef CYC_CTRL_ERR_INJ_EN
      inj_en_d  = inj_en;
      inj_pos_d = inj_pos;
`endif
    end
    if (reset) begin
      data_ready = 1'b0;
      enc_enable = 1'b0;
      enc_reset  = 1'b1;
      enc_in     = 1'b0;
    end
  end

  // Frame control registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
    end
  end

`ifdef CYC_CTRL_ERR_INJ_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      inj_en_q  <= 1'b0;
      inj_pos_q <= '0;
    end else begin
      inj_en_q  <= inj_en_d;
      inj_pos_q <= inj_pos_d;
    end
  end
`endif

  // Tag for the bit entering the encoder this cycle; the counter equals the transmit index
  always_comb begin
    tag_now = '0;
    if (enc_enable) begin
      tag_now[T_V]   = 1'b1;
      tag_now[T_SOF] = (state_q == S_DATA) && (cnt_q == '0);
      tag_now[T_EOF] = last_par;
`ifdef CYC_CTRL_ERR_INJ_EN
      // Flip decided at drive time so a later acceptance cannot disturb bits in flight
      tag_now[T_FLIP] = inj_en_q && (cnt_q == inj_pos_q);
`endif
    end
  end

  // Delay tags by ENC_LAT so they line up with the encoder's output bit
  if (ENC_LAT == 0) begin : g_no_pipe
    assign tag_al    = tag_now;
    assign pipe_busy = 1'b0;
  end else begin : g_pipe
    localparam int unsigned PW = ENC_LAT * TW;
    localparam logic [PW-1:0] VMASK = {ENC_LAT{TW'(1 << T_V)}};
    logic [PW-1:0] pipe_q, pipe_d;

    always_comb begin
      pipe_d = (pipe_q << TW) | PW'(tag_now);
    end

    always_ff @(posedge clk) begin
      if (reset) pipe_q <= '0;
      else       pipe_q <= pipe_d;
    end

    assign tag_al    = pipe_q[PW-1 -: TW];
    assign pipe_busy = |(pipe_q & VMASK);
  end

  // Output stage: capture enc_out together with its aligned tag
  always_comb begin
    code_valid_d = tag_al[T_V];
    code_sof_d   = tag_al[T_SOF];
    code_eof_d   = tag_al[T_EOF];
    code_bit_d   = tag_al[T_V] & (enc_out ^ tag_al[T_FLIP]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      code_bit_q   <= 1'b0;
      code_valid_q <= 1'b0;
      code_sof_q   <= 1'b0;
      code_eof_q   <= 1'b0;
    end else begin
      code_bit_q   <= code_bit_d;
      code_valid_q <= code_valid_d;
      code_sof_q   <= code_sof_d;
      code_eof_q   <= code_eof_d;
    end
  end

  // Outputs forced quiet in any reset cycle, including the first one
  assign code_out   = code_bit_q   & ~reset;
  assign code_valid = code_valid_q & ~reset;
  assign code_sof   = code_sof_q   & ~reset;
  assign code_eof   = code_eof_q   & ~reset;
  assign busy       = ~reset & ((state_q != S_IDLE) | pipe_busy | code_valid_q);

endmodule

// File: tb/tb_cyclic_frame_ctrl.sv
// Bench for cyclic_frame_ctrl: three instances (ENC_LAT 0, 1, 3) share the
// same stimulus and a behavioural g = x^4+x+1 encoder whose output is delayed
// per lane. Codewords are collected per lane and compared to hand-computed values.
module tb_cyclic_frame_ctrl;

  localparam int unsigned K  = 11;
  localparam int unsigned N  = 15;
  localparam int unsigned NL = 3;
  localparam int unsigned MF = 32;
  localparam logic [11:0] LATV = {4'd3, 4'd1, 4'd0};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          data_valid;
  logic [K-1:0]  data_in;
`ifdef CYC_CTRL_ERR_INJ_EN
  logic          inj_en;
  logic [3:0]    inj_pos;
`endif

  logic [NL-1:0] ready_w, eenb_w, erst_w, ein_w, eout_w;
  logic [NL-1:0] cout_w, cv_w, cs_w, ce_w, busy_w;

  for (genvar g = 0; g < NL; g++) begin : g_dut
    cyclic_frame_ctrl #(
      .K(K), .N(N), .ENC_LAT(int'(LATV[g*4 +: 4]))
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .data_in    (data_in),
      .data_valid (data_valid),
      .data_ready (ready_w[g]),
      .enc_enable (eenb_w[g]),
      .enc_reset  (erst_w[g]),
      .enc_in     (ein_w[g]),
      .enc_out    (eout_w[g]),
      .code_out   (cout_w[g]),
      .code_valid (cv_w[g]),
      .code_sof   (cs_w[g]),
      .code_eof   (ce_w[g]),
      .busy       (busy_w[g])
`ifdef CYC_CTRL_ERR_INJ_EN
      ,
      .inj_en     (inj_en),
      .inj_pos    (inj_pos)
`endif
    );
  end

  // Behavioural systematic encoder: message bits pass through, then the remainder
  logic [3:0]  r;
  int unsigned ecnt;
  logic        e0, d1, d2, d3, fb;
  assign fb = ein_w[0] ^ r[3];
  assign e0 = (ecnt < K) ? ein_w[0] : r[3];
  always @(posedge clk) begin
    if (erst_w[0]) begin
      r    <= 4'b0000;
      ecnt <= 0;
    end else if (eenb_w[0]) begin
      ecnt <= ecnt + 1;
      if (ecnt < K) r <= {r[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      else          r <= {r[2:0], 1'b0};
    end
    d1 <= e0;
    d2 <= d1;
    d3 <= d2;
  end
  assign eout_w = {d3, d1, e0};

  // Stream monitor
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0] fw   [NL][MF];
  bit           fok  [NL][MF];
  int unsigned  fsof [NL][MF];
  int unsigned  feof [NL][MF];
  int           fn   [NL];
  logic [N-1:0] accw [NL];
  int           idx  [NL];
  bit           inf  [NL];
  int unsigned  cur_sof [NL];
  int           stray [NL];
  int unsigned  bdrop [NL];
  bit           bprev [NL];
  int unsigned  acc_at [64];
  int           acc_cnt = 0;
  int           clr_cnt = 0;

  initial begin
    for (int l = 0; l < NL; l++) begin
      fn[l] = 0; idx[l] = 0; inf[l] = 0; stray[l] = 0; bdrop[l] = 0; bprev[l] = 0;
      accw[l] = '0; cur_sof[l] = 0;
    end
  end

  always @(negedge clk) begin
    if (!reset && data_valid && ready_w[0]) begin
      if (acc_cnt < 64) acc_at[acc_cnt] = cyc;
      acc_cnt++;
    end
    if (!reset && erst_w[0]) clr_cnt++;
    for (int l = 0; l < NL; l++) begin
      if (reset) begin
        inf[l] = 0;
        idx[l] = 0;
      end else if (cv_w[l]) begin
        if (cs_w[l]) begin
          inf[l] = 1; idx[l] = 0; accw[l] = '0; cur_sof[l] = cyc;
        end else if (!inf[l]) begin
          stray[l]++;
        end
        accw[l] = {accw[l][N-2:0], cout_w[l]};
        idx[l]++;
        if (ce_w[l]) begin
          if (fn[l] < MF) begin
            fw[l][fn[l]]   = accw[l];
            fok[l][fn[l]]  = inf[l] && (idx[l] == N);
            fsof[l][fn[l]] = cur_sof[l];
            feof[l][fn[l]] = cyc;
          end
          fn[l]++;
          inf[l] = 0;
        end
      end
      if (bprev[l] && !busy_w[l]) bdrop[l] = cyc;
      bprev[l] = busy_w[l];
    end
  end

  // Checking helpers
  int n_run  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [K-1:0] d);
    int n = 0;
    data_in    = d;
    data_valid = 1'b1;
    while (!ready_w[0] && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("send_ready", 32'(ready_w[0]), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy_w != '0 && n < 300);
    chk("drain_busy", 32'(busy_w), 32'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [K-1:0] d;
    logic [N-1:0] cw;
  } vec_t;

  vec_t vt [5];
  int   bf [NL];
  int   ba, bc;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{11'b00000001010, 15'b000000010101101};
    vt[1] = '{11'b00000000001, 15'b000000000010011};
    vt[2] = '{11'b00000000000, 15'b000000000000000};
    vt[3] = '{11'b10000000000, 15'b100000000001001};
    vt[4] = '{11'b11111111111, 15'b111111111111111};

    reset      = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
`ifdef CYC_CTRL_ERR_INJ_EN
    inj_en     = 1'b0;
    inj_pos    = 4'd0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready",  32'(ready_w), 32'd0);
    chk("rst_encrst", 32'(erst_w),  32'h7);
    chk("rst_encen",  32'(eenb_w),  32'd0);
    chk("rst_encin",  32'(ein_w),   32'd0);
    chk("rst_valid",  32'(cv_w),    32'd0);
    chk("rst_busy",   32'(busy_w),  32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_ready",  32'(ready_w), 32'h7);
    chk("idle_encrst", 32'(erst_w),  32'd0);
    chk("idle_busy",   32'(busy_w),  32'd0);

    // Back-to-back batch from the vector table
    for (int l = 0; l < NL; l++) bf[l] = fn[l];
    ba = acc_cnt;
    bc = clr_cnt;
    for (int i = 0; i < 5; i++) send(vt[i].d);
    data_valid = 1'b0;
    drain();
    chk("batch_accepts", 32'(acc_cnt - ba), 32'd5);
    chk("batch_clr",     32'(clr_cnt - bc), 32'd5);
    chk("post_encen",    32'(eenb_w),  32'd0);
    chk("post_ready",    32'(ready_w), 32'h7);
    for (int l = 0; l < NL; l++) begin
      int lat;
      lat = int'(LATV[l*4 +: 4]);
      chk($sformatf("frames_l%0d", l), 32'(fn[l] - bf[l]), 32'd5);
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("cw_l%0d_v%0d", l, i),    32'(fw[l][bf[l]+i]),  32'(vt[i].cw));
        chk($sformatf("frame_l%0d_v%0d", l, i), 32'(fok[l][bf[l]+i]), 32'd1);
        if (i > 0)
          chk($sformatf("gap_l%0d_v%0d", l, i),
              32'(fsof[l][bf[l]+i] - feof[l][bf[l]+i-1]), 32'd2);
      end
      chk($sformatf("sof_lat_l%0d", l), 32'(fsof[l][bf[l]] - acc_at[ba]), 32'(lat + 3));
      chk($sformatf("busy_drop_l%0d", l), 32'(bdrop[l]), 32'(feof[l][bf[l]+4] + 1));
    end

    // Reset in the middle of DATA (counter 5)
    send(11'b01010100101);
    data_valid = 1'b0;
    chk("clr_pulse",  32'(erst_w[0]),  32'd1);
    chk("clr_ready",  32'(ready_w[0]), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("data_ready_low", 32'(ready_w[0]), 32'd0);
    chk("data_encen",     32'(eenb_w[0]),  32'd1);
    for (int l = 0; l < NL; l++) bf[l] = fn[l];
    reset = 1'b1;
    #1;
    chk("mid_rst_encrst", 32'(erst_w),  32'h7);
    chk("mid_rst_encen",  32'(eenb_w),  32'd0);
    chk("mid_rst_ready",  32'(ready_w), 32'd0);
    chk("mid_rst_busy",   32'(busy_w),  32'd0);
    chk("mid_rst_valid",  32'(cv_w),    32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("after_rst_idle",  32'(ready_w), 32'h7);
    chk("after_rst_valid", 32'(cv_w),    32'd0);
    chk("after_rst_encen", 32'(eenb_w),  32'd0);
    repeat (25) @(posedge clk);
    #1;
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("no_eof_l%0d", l), 32'(fn[l] - bf[l]), 32'd0);
      chk($sformatf("stray_l%0d", l),  32'(stray[l]),       32'd0);
    end
    send(vt[3].d);
    data_valid = 1'b0;
    drain();
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("rec_cw_l%0d", l),    32'(fw[l][bf[l]]),  32'(vt[3].cw));
      chk($sformatf("rec_frame_l%0d", l), 32'(fok[l][bf[l]]), 32'd1);
    end

    // Reset and data_valid together: word must be dropped
    for (int l = 0; l < NL; l++) bf[l] = fn[l];
    data_in    = 11'b11111111111;
    data_valid = 1'b1;
    reset      = 1'b1;
    @(posedge clk); #1;
    data_valid = 1'b0;
    reset      = 1'b0;
    #1;
    chk("rstwin_encrst", 32'(erst_w),  32'd0);
    chk("rstwin_ready",  32'(ready_w), 32'h7);
    chk("rstwin_busy",   32'(busy_w),  32'd0);
    repeat (25) @(posedge clk);
    #1;
    chk("rstwin_frames", 32'(fn[0] - bf[0]), 32'd0);

`ifdef CYC_CTRL_ERR_INJ_EN
    // Injection: bit 14 flipped, then an out-of-range position leaves the word intact
    for (int l = 0; l < NL; l++) bf[l] = fn[l];
    inj_en  = 1'b1;
    inj_pos = 4'd14;
    send(11'b00000000001);
    inj_pos = 4'd15;
    send(11'b00000000001);
    data_valid = 1'b0;
    inj_en     = 1'b0;
    drain();
    for (int l = 0; l < NL; l++) begin
      chk($sformatf("inj14_l%0d", l), 32'(fw[l][bf[l]]),   32'(15'b000000000010010));
      chk($sformatf("inj15_l%0d", l), 32'(fw[l][bf[l]+1]), 32'(15'b000000000010011));
    end
`endif

    for (int l = 0; l < NL; l++) chk($sformatf("stray_end_l%0d", l), 32'(stray[l]), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
